led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//  Button-driven controller for the ULX3S 8-LED bank. Debounces user buttons and
//  sequences one of four LED patterns at a selectable step rate. Pause, mode and
//  speed are all controlled from the buttons. Sits between the board pins and led[7:0].
// PARAMETERS
//  DEBOUNCE_CYCLES  250000   stable cycles before a button change is accepted (10 ms @ 25 MHz)
//  TICK_BASE        1048576  cycles per pattern step at speed 0; power of two, >= 16
// PORTS
//  i_clk       in   1  system clock
//  i_rst       in   1  synchronous reset, active-high
//  btn         in   7  raw buttons, 1 = pressed; btn[0], btn[5], btn[6] ignored
//  led         out  8  pattern output, registered
//  o_mode      out  2  current pattern: 0 BINARY, 1 SCANNER, 2 GRAY, 3 FILL
//  o_speed     out  2  current speed level, 0 = slowest
//  o_paused    out  1  1 while stepping is frozen
// BEHAVIOUR
//  Clocking: one clock (i_clk). Reset is synchronous and active-high (i_rst).
//  Reset values: led=0, o_mode=0, o_speed=0, o_paused=0, step=0, prescaler=0,
//    dir=up, all debounced states=0, all debounce counters=0.
//  Button path, per button btn[1..4]:
//    - 2-flop synchroniser.
//    - Counter resets on any mismatch between synced and debounced value.
//    - Debounced value updates when DEBOUNCE_CYCLES consecutive mismatching
//      cycles have been seen.
//    - Press event = single-cycle pulse on debounced 0->1. Release generates no event.
//  Events:
//    - btn[1]: toggle o_paused.
//    - btn[2]: o_mode <= o_mode+1 (wraps 3->0). On the same cycle: step=0,
//      dir=up, prescaler=0.
//    - btn[3]: speed up, saturates at 3.
//    - btn[4]: speed down, saturates at 0.
//    - Simultaneous btn[3]&btn[4] events: no speed change.
//    - Simultaneous btn[2] with any other event: all events apply in the same cycle.
//  Prescaler:
//    - Free-running counter, held while o_paused=1.
//    - Produces a tick when it reaches (TICK_BASE>>o_speed)-1, then clears.
//    - On a speed change the prescaler clears, so the next tick is a full new
//      period later.
//  Pattern step, on tick only:
//    - BINARY: step 0..255 wraps. led = step[7:0].
//    - GRAY: same counter as BINARY. led = step ^ (step>>1).
//    - SCANNER: one-hot index 0..7, led = 1<<idx.
//        - Index increments while dir=up. At idx 7, dir flips to down on the
//          same tick.
//        - At idx 0 while dir=down, dir flips to up. Endpoints are shown once.
//    - FILL: step 0..15. led = step<8 ? (8'hFF >> (7-step)) : (8'hFF << (step-7)).
//        - After 15, wraps to 0.
//  Output timing:
//    - led is registered from the state after the update: the new pattern is
//      visible 1 cycle after the tick or mode event.
//    - After a mode change, led shows step 0 of the new mode.
//  Pause:
//    - While paused, led holds and the prescaler holds.
//    - Mode and speed events still apply, and led updates to step 0 of a new mode.
//  Mid-operation reset: i_rst wins over any same-cycle event. All state returns
//    to reset values on the next edge.
// TESTING (bench uses DEBOUNCE_CYCLES=4, TICK_BASE=16)
//  1. Reset, run 40 cycles -> led steps 0,1,2 with one step every 16 cycles.
//     o_mode=0, o_paused=0.
//  2. Bounce btn[2] 1-0-1 with 2-cycle gaps, then hold it high for 8 cycles
//     -> exactly one mode event. o_mode=1, led=8'h01.
//  3. Mode 1, speed 3 (2-cycle ticks), run 32 cycles -> led sequence
//     01,02,..,80,40,..,01,02. 80 and 01 each appear once per bounce.
//  4. Press btn[1] mid-run -> o_paused=1, led frozen 100 cycles.
//     Press again -> resumes from the same value.
//  5. Press btn[3] four times -> o_speed saturates at 3.
//     Press btn[3] and btn[4] in the same cycle -> o_speed unchanged.
//  6. Mode 3 running, assert i_rst for 1 cycle at an arbitrary point -> next
//     cycle all outputs 0. Mode 3 FILL check: led 01,03,..,FF,FE,..,80,00.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// Button-driven LED pattern sequencer for an 8-LED bank.
// Four debounced buttons control pause, pattern mode and step rate; a
// prescaler paces the pattern steps and led[7:0] is driven from a register.
module led_pattern_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_BASE       = 1048576
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] btn,
  output logic [7:0] led,
  output logic [1:0] o_mode,
  output logic [1:0] o_speed,
  output logic       o_paused
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PS_W = $clog2(TICK_BASE);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'd0,
    MODE_SCANNER = 2'd1,
    MODE_GRAY    = 2'd2,
    MODE_FILL    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Buttons 0, 5 and 6 have no function on this board.
  logic unused_btn;
  assign unused_btn = ^{btn[6:5], btn[0]};

  // ---------------------------------------------------------------------------
  // Button conditioning for btn[4:1]
  // ---------------------------------------------------------------------------
  logic [4:1]      sync1_q, sync2_q, deb_q, press_q;
  logic [DB_W-1:0] db_cnt_q [1:4];

  // Synchronise, debounce, and emit a one-cycle pulse on each accepted press.
  always_ff @(posedge i_clk) begin
    // NOTE: the synchronisers are reset along with everything else so a reset
    // in the middle of a bounce cannot leave a half-accepted press behind.
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 1; i <= 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn[4:1];
      sync2_q <= sync1_q;
      for (int i = 1; i <= 4; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          press_q[i]  <= sync2_q[i];  // only the 0->1 edge is an event
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  logic ev_pause, ev_mode, ev_up, ev_down;
  assign ev_pause = press_q[1];
  assign ev_mode  = press_q[2];
  assign ev_up    = press_q[3];
  assign ev_down  = press_q[4];

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  mode_e           mode_q,   mode_d;
  dir_e            dir_q,    dir_d;
  logic [1:0]      speed_q,  speed_d;
  logic            paused_q, paused_d;
  logic [7:0]      step_q,   step_d;
  logic [PS_W-1:0] presc_q,  presc_d;
  logic [7:0]      led_q,    led_d;

  logic [PS_W-1:0] tick_limit;
  logic            tick;

  assign tick_limit = PS_W'((TICK_BASE >> speed_q) - 1);
  assign tick       = !paused_q && (presc_q == tick_limit);

  // LED image for a given mode and step counter.
  function automatic logic [7:0] pattern(input mode_e m, input logic [7:0] s);
    logic [7:0] r;
    r = s;
    case (m)
      MODE_BINARY:  r = s;
      MODE_SCANNER: r = 8'd1 << s[2:0];
      MODE_GRAY:    r = s ^ (s >> 1);
      MODE_FILL:    r = (s[3:0] < 4'd8) ? (8'hFF >> (3'd7 - s[2:0]))
                                        : (8'hFF << (s[3:0] - 4'd7));
      default:      r = s;
    endcase
    return r;
  endfunction

  // Next-state logic: button events, prescaler, pattern step and LED image.
  always_comb begin
    // NOTE: every signal gets its hold value first; without these defaults the
    // branches that do not assign would infer latches.
    mode_d   = mode_q;
    dir_d    = dir_q;
    speed_d  = speed_q;
    paused_d = paused_q;
    step_d   = step_q;
    presc_d  = presc_q;

    if (ev_pause) paused_d = ~paused_q;

    // Opposing speed events cancel; each direction saturates.
    if (ev_up && !ev_down && speed_q != 2'd3)      speed_d = speed_q + 2'd1;
    else if (ev_down && !ev_up && speed_q != 2'd0) speed_d = speed_q - 2'd1;

    if (!paused_q) presc_d = tick ? '0 : presc_q + PS_W'(1);
    // A new rate starts a full period from now.
    if (speed_d != speed_q) presc_d = '0;

    if (tick) begin
      case (mode_q)
        MODE_SCANNER: begin
          // Direction flips on the tick that lands on an end, so each end
          // is shown exactly once per sweep.
          if (dir_q == DIR_UP) begin
            step_d = step_q + 8'd1;
            if (step_q[2:0] == 3'd6) dir_d = DIR_DOWN;
          end else begin
            step_d = step_q - 8'd1;
            if (step_q[2:0] == 3'd1) dir_d = DIR_UP;
          end
        end
        MODE_FILL: step_d = {4'd0, step_q[3:0] + 4'd1};
        default:   step_d = step_q + 8'd1;
      endcase
    end

    // A mode change restarts the new pattern from its first step.
    if (ev_mode) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      step_d  = 8'd0;
      dir_d   = DIR_UP;
      presc_d = '0;
    end

    led_d = pattern(mode_d, step_d);
  end

  // State and output registers; reset overrides any same-cycle event.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (i_rst) begin
      mode_q   <= MODE_BINARY;
      dir_q    <= DIR_UP;
      speed_q  <= 2'd0;
      paused_q <= 1'b0;
      step_q   <= 8'd0;
      presc_q  <= '0;
      led_q    <= 8'd0;
    end else begin
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
      step_q   <= step_d;
      presc_q  <= presc_d;
      led_q    <= led_d;
    end
  end

  assign led      = led_q;
  assign o_mode   = mode_q;
  assign o_speed  = speed_q;
  assign o_paused = paused_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with short debounce and tick periods.
module tb_led_pattern_sequencer;

  localparam int DB = 4;
  localparam int TB = 16;

  localparam logic [6:0] B_PAUSE = 7'b0000010;
  localparam logic [6:0] B_MODE  = 7'b0000100;
  localparam logic [6:0] B_UP    = 7'b0001000;
  localparam logic [6:0] B_DOWN  = 7'b0010000;

  localparam logic [7:0] SCAN_TBL [14] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02
  };
  localparam logic [7:0] FILL_TBL [16] = '{
    8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00
  };

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [6:0] btn;
  logic [7:0] led;
  logic [1:0] o_mode;
  logic [1:0] o_speed;
  logic       o_paused;

  int n_checks = 0;
  int n_errors = 0;

  led_pattern_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_BASE      (TB)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .btn     (btn),
    .led     (led),
    .o_mode  (o_mode),
    .o_speed (o_speed),
    .o_paused(o_paused)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // A clean press: the event lands on the 7th edge; returns once released
  // and debounced back to 0.
  task automatic press(input logic [6:0] mask);
    btn = mask;
    cycles(7);
    btn = '0;
    cycles(7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- 1: reset and free-running binary count ----
    i_rst = 1'b1;
    btn   = '0;
    cycles(3);
    check("rst_led",    32'(led),      0);
    check("rst_mode",   32'(o_mode),   0);
    check("rst_speed",  32'(o_speed),  0);
    check("rst_paused", 32'(o_paused), 0);
    i_rst = 1'b0;
    cycles(15); check("bin_c15", 32'(led), 'h00);
    cycles(1);  check("bin_c16", 32'(led), 'h01);
    cycles(15); check("bin_c31", 32'(led), 'h01);
    cycles(1);  check("bin_c32", 32'(led), 'h02);
    cycles(8);  check("bin_c40", 32'(led), 'h02);
    check("bin_mode",   32'(o_mode),   0);
    check("bin_paused", 32'(o_paused), 0);

    // ---- 2: bouncing mode button gives one event ----
    btn = B_MODE; cycles(2);
    btn = '0;     cycles(2);
    btn = B_MODE; cycles(7);
    check("bounce_mode", 32'(o_mode), 1);
    check("bounce_led",  32'(led),    'h01);
    cycles(1);
    btn = '0;
    cycles(9);
    check("bounce_mode_after", 32'(o_mode), 1);
    check("bounce_led_after",  32'(led),    'h01);

    // ---- 5a: speed up saturates at 3 ----
    for (int s = 1; s <= 4; s++) begin
      press(B_UP);
      check($sformatf("speed_up_%0d", s), 32'(o_speed), (s > 3) ? 3 : s);
    end

    // ---- 3: scanner at speed 3, restarted by a mode wrap back to 1 ----
    press(B_MODE);
    press(B_MODE);
    press(B_MODE);
    check("mode_wrap", 32'(o_mode), 0);
    btn = B_MODE;
    cycles(7);
    btn = '0;
    check("scan_mode", 32'(o_mode), 1);
    check("scan_n0", 32'(led), 32'(SCAN_TBL[0]));
    for (int n = 1; n < 32; n++) begin
      cycles(1);
      check($sformatf("scan_n%0d", n), 32'(led), 32'(SCAN_TBL[(n / 2) % 14]));
    end

    // ---- 4: pause freezes, resume continues ----
    btn = B_PAUSE;
    cycles(7);
    btn = '0;
    check("pause_on",  32'(o_paused), 1);
    check("pause_led", 32'(led),      'h20);
    for (int i = 0; i < 10; i++) begin
      cycles(10);
      check($sformatf("pause_hold_%0d", i), 32'(led), 'h20);
    end
    btn = B_PAUSE;
    cycles(7);
    check("pause_off",    32'(o_paused), 0);
    check("resume_led0",  32'(led),      'h20);
    cycles(2);
    check("resume_led1",  32'(led),      'h40);
    btn = '0;
    cycles(7);

    // ---- 5b: speed down saturates at 0, simultaneous up/down is a no-op ----
    for (int s = 1; s <= 4; s++) begin
      press(B_DOWN);
      check($sformatf("speed_dn_%0d", s), 32'(o_speed), (s > 3) ? 0 : 3 - s);
    end
    press(B_UP);
    check("speed_up_a", 32'(o_speed), 1);
    press(B_UP);
    check("speed_up_b", 32'(o_speed), 2);
    press(B_UP | B_DOWN);
    check("speed_both", 32'(o_speed), 2);

    // ---- 6: fill pattern at speed 2, then mid-run reset ----
    press(B_MODE);
    check("mode_gray", 32'(o_mode), 2);
    btn = B_MODE;
    cycles(7);
    btn = '0;
    check("fill_mode", 32'(o_mode), 3);
    check("fill_k0",   32'(led),    32'(FILL_TBL[0]));
    for (int k = 1; k <= 16; k++) begin
      cycles(4);
      check($sformatf("fill_k%0d", k), 32'(led), 32'(FILL_TBL[k % 16]));
    end
    cycles(2);
    i_rst = 1'b1;
    btn   = B_MODE | B_UP;
    cycles(1);
    check("mid_rst_led",    32'(led),      0);
    check("mid_rst_mode",   32'(o_mode),   0);
    check("mid_rst_speed",  32'(o_speed),  0);
    check("mid_rst_paused", 32'(o_paused), 0);
    i_rst = 1'b0;
    btn   = '0;
    cycles(15); check("post_rst_c15", 32'(led), 'h00);
    cycles(1);  check("post_rst_c16", 32'(led), 'h01);
    check("post_rst_mode", 32'(o_mode), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
